// File: rtl/vuop_sequencer_pkg.sv
// rtl/vuop_sequencer_pkg.sv - vtype encodings, request/uop records and group-geometry helpers
package vuop_sequencer_pkg;

  localparam int NUM_LANES = 4;
  localparam int VL_W      = 8;
  localparam int VLENB     = 16;

  typedef enum logic [2:0] {
    SEW8 = 3'd0, SEW16 = 3'd1, SEW32 = 3'd2, SEW64 = 3'd3,
    SEW_R4 = 3'd4, SEW_R5 = 3'd5, SEW_R6 = 3'd6, SEW_R7 = 3'd7
  } vsew_t;

  typedef enum logic [2:0] {
    LMUL1 = 3'd0, LMUL2 = 3'd1, LMUL4 = 3'd2, LMUL8 = 3'd3,
    LMUL_RSVD = 3'd4, LMUL_F8 = 3'd5, LMUL_F4 = 3'd6, LMUL_F2 = 3'd7
  } vlmul_t;

  typedef struct packed {
    vsew_t           vsew;
    vlmul_t          vlmul;
    logic            vill;
    logic [VL_W-1:0] vl;
    logic [4:0]      vd;
    logic [4:0]      vs1;
    logic [4:0]      vs2;
  } vuop_req_t;

  typedef struct packed {
    logic [4:0]                vd;
    logic [4:0]                vs1;
    logic [4:0]                vs2;
    logic [4:0]                vuop_num;
    logic                      last;
    logic [NUM_LANES-1:0]      vlaneactive;
    logic [NUM_LANES-1:0][3:0] vbyte_en;
  } vuop_t;

  function automatic logic [VL_W-1:0] elems_per_reg(vsew_t vsew);
    return 8'(VLENB) >> vsew;
  endfunction

  // Fractional LMUL still occupies one whole register.
  function automatic logic [VL_W-1:0] regs_per_group(vlmul_t vlmul);
    case (vlmul)
      LMUL2:   return 8'd2;
      LMUL4:   return 8'd4;
      LMUL8:   return 8'd8;
      default: return 8'd1;
    endcase
  endfunction

endpackage

// File: rtl/vuop_byte_mask.sv
// rtl/vuop_byte_mask.sv - per-byte write enables of one uop from SEW, vl and uop index
// Optional VUOP_VSTART_EN adds a lower element bound.
module vuop_byte_mask
  import vuop_sequencer_pkg::*;
(
  input  vsew_t      vsew,
  input  logic [7:0] vl,
`ifdef VUOP_VSTART_EN
  input  logic [7:0] vstart,
`endif
  input  logic [4:0] uop_idx,
  output logic [15:0] byte_en
);

  logic [9:0] base;

  assign base = 10'(uop_idx) * 10'(elems_per_reg(vsew));

  always_comb begin
    byte_en = '0;
    for (int k = 0; k < 16; k++) begin
`ifdef VUOP_VSTART_EN
      byte_en[k] = ((base + (10'(k) >> vsew)) < 10'(vl)) &&
                   ((base + (10'(k) >> vsew)) >= 10'(vstart));
`else
      byte_en[k] = (base + (10'(k) >> vsew)) < 10'(vl);
`endif
    end
  end

endmodule

// File: rtl/vuop_sequencer.sv
// rtl/vuop_sequencer.sv - splits a decoded vector instruction into per-register uops
// Optional VUOP_VSTART_EN adds in_vstart (leading-element suppression and uop skipping).
module vuop_sequencer
  import vuop_sequencer_pkg::*;
(
  input  logic        CLK,
  input  logic        nRST,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_vsew,
  input  logic [2:0]  in_vlmul,
  input  logic        in_vill,
  input  logic [7:0]  in_vl,
`ifdef VUOP_VSTART_EN
  input  logic [7:0]  in_vstart,
`endif
  input  logic [4:0]  in_vd,
  input  logic [4:0]  in_vs1,
  input  logic [4:0]  in_vs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_vd,
  output logic [4:0]  out_vs1,
  output logic [4:0]  out_vs2,
  output logic [4:0]  out_vuop_num,
  output logic        out_last,
  output logic [3:0]  out_vlaneactive,
  output logic [15:0] out_vbyte_en,
  output logic        done,
  output logic        illegal
);

  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  state_t     state_q, state_d;
  vsew_t      vsew_q;
  logic [7:0] vl_q;
  logic [4:0] vd_q, vs1_q, vs2_q, idx_q, last_q;
  logic       done_q, illegal_q;
`ifdef VUOP_VSTART_EN
  logic [7:0] vstart_q;
`endif

  vuop_req_t  req_in;
  logic       illegal_in, zero_in, accept, hs, hs_last, load, advance;
  logic [7:0] epr_in, maxvl_in, vl_eff;
  logic [8:0] nregs_in;
  logic [4:0] start_in, last_in;
  logic [15:0] byte_en;
  vuop_t      uop;

  assign req_in = '{vsew: vsew_t'(in_vsew), vlmul: vlmul_t'(in_vlmul), vill: in_vill,
                    vl: in_vl, vd: in_vd, vs1: in_vs1, vs2: in_vs2};

  // Long vl is clamped to the group size; uop count is ceil(vl/epr) of the clamped value.
  always_comb begin
    illegal_in = req_in.vill || (in_vsew > 3'd2) || (req_in.vlmul == LMUL_RSVD);
    epr_in     = elems_per_reg(req_in.vsew);
    maxvl_in   = regs_per_group(req_in.vlmul) * epr_in;
    vl_eff     = (req_in.vl > maxvl_in) ? maxvl_in : req_in.vl;
    nregs_in   = (9'(vl_eff) + 9'(epr_in) - 9'd1) >> (3'd4 - 3'(req_in.vsew));
    last_in    = 5'(nregs_in - 9'd1);
`ifdef VUOP_VSTART_EN
    start_in   = 5'(in_vstart >> (3'd4 - 3'(req_in.vsew)));
    zero_in    = illegal_in || (vl_eff == 8'd0) || (in_vstart >= vl_eff);
`else
    start_in   = 5'd0;
    zero_in    = illegal_in || (vl_eff == 8'd0);
`endif
  end

  assign out_valid = (state_q == ISSUE);
  assign hs        = out_valid && out_ready;
  assign hs_last   = hs && out_last;
  assign in_ready  = nRST && ((state_q == IDLE) || hs_last);
  assign accept    = in_valid && in_ready && !flush;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    advance = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept && !zero_in) begin
          state_d = ISSUE;
          load    = 1'b1;
        end
      end
      ISSUE: begin
        if (flush) begin
          state_d = IDLE;
        end else if (hs_last) begin
          if (accept && !zero_in) load = 1'b1;
          else state_d = IDLE;
        end else if (hs) begin
          advance = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= IDLE;
      vsew_q    <= SEW8;
      vl_q      <= '0;
      vd_q      <= '0;
      vs1_q     <= '0;
      vs2_q     <= '0;
      idx_q     <= '0;
      last_q    <= '0;
      done_q    <= 1'b0;
      illegal_q <= 1'b0;
`ifdef VUOP_VSTART_EN
      vstart_q  <= '0;
`endif
    end else begin
      state_q   <= state_d;
      done_q    <= accept && zero_in;
      illegal_q <= accept && illegal_in;
      if (load) begin
        vsew_q <= req_in.vsew;
        vl_q   <= vl_eff;
        vd_q   <= req_in.vd;
        vs1_q  <= req_in.vs1;
        vs2_q  <= req_in.vs2;
        idx_q  <= start_in;
        last_q <= last_in;
`ifdef VUOP_VSTART_EN
        vstart_q <= in_vstart;
`endif
      end else if (advance) begin
        idx_q <= idx_q + 5'd1;
      end
    end
  end

  vuop_byte_mask u_mask (
    .vsew    (vsew_q),
    .vl      (vl_q),
`ifdef VUOP_VSTART_EN
    .vstart  (vstart_q),
`endif
    .uop_idx (idx_q),
    .byte_en (byte_en)
  );

  always_comb begin
    uop          = '0;
    uop.vd       = vd_q + idx_q;
    uop.vs1      = vs1_q + idx_q;
    uop.vs2      = vs2_q + idx_q;
    uop.vuop_num = idx_q;
    uop.last     = out_valid && (idx_q == last_q);
    uop.vbyte_en = byte_en;
    for (int j = 0; j < NUM_LANES; j++) uop.vlaneactive[j] = |uop.vbyte_en[j];
  end

  assign out_vd          = uop.vd;
  assign out_vs1         = uop.vs1;
  assign out_vs2         = uop.vs2;
  assign out_vuop_num    = uop.vuop_num;
  assign out_last        = uop.last;
  assign out_vlaneactive = uop.vlaneactive;
  assign out_vbyte_en    = uop.vbyte_en;
  assign done            = done_q || (hs_last && !flush);
  assign illegal         = illegal_q;

endmodule

// File: tb/tb_vuop_sequencer.sv
// tb/tb_vuop_sequencer.sv - table-driven and sequence checks for vuop_sequencer
module tb_vuop_sequencer;

  logic        CLK = 1'b0;
  logic        nRST = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_vsew = '0;
  logic [2:0]  in_vlmul = '0;
  logic        in_vill = 1'b0;
  logic [7:0]  in_vl = '0;
`ifdef VUOP_VSTART_EN
  logic [7:0]  in_vstart = '0;
`endif
  logic [4:0]  in_vd = '0, in_vs1 = '0, in_vs2 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [4:0]  out_vd, out_vs1, out_vs2, out_vuop_num;
  logic        out_last;
  logic [3:0]  out_vlaneactive;
  logic [15:0] out_vbyte_en;
  logic        done, illegal;

  int checks = 0;
  int failures = 0;

  vuop_sequencer dut (
    .CLK(CLK), .nRST(nRST), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_vsew(in_vsew), .in_vlmul(in_vlmul), .in_vill(in_vill), .in_vl(in_vl),
`ifdef VUOP_VSTART_EN
    .in_vstart(in_vstart),
`endif
    .in_vd(in_vd), .in_vs1(in_vs1), .in_vs2(in_vs2),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_vd(out_vd), .out_vs1(out_vs1), .out_vs2(out_vs2),
    .out_vuop_num(out_vuop_num), .out_last(out_last),
    .out_vlaneactive(out_vlaneactive), .out_vbyte_en(out_vbyte_en),
    .done(done), .illegal(illegal)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [2:0]  sew;
    logic [2:0]  lmul;
    logic        vill;
    logic [7:0]  vl;
    logic [4:0]  vd, vs1, vs2;
    int          n;
    logic        ill;
    logic [15:0] be;
    logic [3:0]  ln;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic drive(input logic [2:0] sew, input logic [2:0] lmul, input logic vill,
                       input logic [7:0] vl, input logic [4:0] vd, input logic [4:0] vs1,
                       input logic [4:0] vs2);
    in_vsew = sew; in_vlmul = lmul; in_vill = vill; in_vl = vl;
    in_vd = vd; in_vs1 = vs1; in_vs2 = vs2;
    in_valid = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int t);
    string tag;
    logic [4:0] ev;
    tag = $sformatf("vec%0d", t);
    drive(v.sew, v.lmul, v.vill, v.vl, v.vd, v.vs1, v.vs2);
    out_ready = 1'b1;
    #2;
    chk({tag, ".in_ready"}, in_ready, 1);
    step();
    in_valid = 1'b0;
    #2;
    if (v.n == 0) begin
      chk({tag, ".no_valid"}, out_valid, 0);
      chk({tag, ".done"}, done, 1);
      chk({tag, ".illegal"}, illegal, v.ill);
      step(); #2;
      chk({tag, ".done_pulse"}, done, 0);
      chk({tag, ".ill_pulse"}, illegal, 0);
    end else begin
      for (int i = 0; i < v.n; i++) begin
        ev = v.vd + 5'(i);
        chk($sformatf("%s.u%0d.valid", tag, i), out_valid, 1);
        chk($sformatf("%s.u%0d.vd", tag, i), out_vd, ev);
        ev = v.vs1 + 5'(i);
        chk($sformatf("%s.u%0d.vs1", tag, i), out_vs1, ev);
        ev = v.vs2 + 5'(i);
        chk($sformatf("%s.u%0d.vs2", tag, i), out_vs2, ev);
        chk($sformatf("%s.u%0d.num", tag, i), out_vuop_num, i);
        chk($sformatf("%s.u%0d.last", tag, i), out_last, (i == v.n - 1));
        chk($sformatf("%s.u%0d.be", tag, i), out_vbyte_en, (i == v.n - 1) ? v.be : 16'hFFFF);
        chk($sformatf("%s.u%0d.lanes", tag, i), out_vlaneactive, (i == v.n - 1) ? v.ln : 4'hF);
        chk($sformatf("%s.u%0d.done", tag, i), done, (i == v.n - 1));
        step(); #2;
      end
      chk({tag, ".end_valid"}, out_valid, 0);
      chk({tag, ".end_done"}, done, 0);
    end
  endtask

  initial begin
    vecs[0]  = '{3'd2, 3'd0, 1'b0, 8'd4,   5'd8,  5'd1,  5'd2,  1, 1'b0, 16'hFFFF, 4'hF};
    vecs[1]  = '{3'd0, 3'd1, 1'b0, 8'd20,  5'd4,  5'd5,  5'd6,  2, 1'b0, 16'h000F, 4'h1};
    vecs[2]  = '{3'd1, 3'd0, 1'b0, 8'd5,   5'd31, 5'd30, 5'd0,  1, 1'b0, 16'h03FF, 4'h7};
    vecs[3]  = '{3'd2, 3'd3, 1'b0, 8'd200, 5'd30, 5'd0,  5'd27, 8, 1'b0, 16'hFFFF, 4'hF};
    vecs[4]  = '{3'd0, 3'd7, 1'b0, 8'd100, 5'd3,  5'd3,  5'd3,  1, 1'b0, 16'hFFFF, 4'hF};
    vecs[5]  = '{3'd2, 3'd1, 1'b0, 8'd5,   5'd10, 5'd12, 5'd14, 2, 1'b0, 16'h000F, 4'h1};
    vecs[6]  = '{3'd2, 3'd0, 1'b0, 8'd0,   5'd1,  5'd1,  5'd1,  0, 1'b0, 16'h0000, 4'h0};
    vecs[7]  = '{3'd3, 3'd0, 1'b0, 8'd8,   5'd1,  5'd1,  5'd1,  0, 1'b1, 16'h0000, 4'h0};
    vecs[8]  = '{3'd2, 3'd0, 1'b1, 8'd4,   5'd1,  5'd1,  5'd1,  0, 1'b1, 16'h0000, 4'h0};
    vecs[9]  = '{3'd2, 3'd4, 1'b0, 8'd4,   5'd1,  5'd1,  5'd1,  0, 1'b1, 16'h0000, 4'h0};
    vecs[10] = '{3'd5, 3'd0, 1'b0, 8'd4,   5'd1,  5'd1,  5'd1,  0, 1'b1, 16'h0000, 4'h0};

    // reset state
    step(); step(); #2;
    chk("rst.valid", out_valid, 0);
    chk("rst.done", done, 0);
    chk("rst.illegal", illegal, 0);
    chk("rst.be", out_vbyte_en, 0);
    chk("rst.last", out_last, 0);
    chk("rst.vd", out_vd, 0);
    nRST = 1'b1;
    step(); #2;
    chk("rst.in_ready", in_ready, 1);

    for (int t = 0; t < 11; t++) run_vec(vecs[t], t);

    // stall on uop1: SEW16 LMUL4 vl=32 -> 4 uops
    drive(3'd1, 3'd2, 1'b0, 8'd32, 5'd16, 5'd0, 5'd0);
    out_ready = 1'b1;
    #2; step(); in_valid = 1'b0; #2;
    chk("stall.u0.num", out_vuop_num, 0);
    step();
    out_ready = 1'b0;
    #2;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("stall.c%0d.valid", c), out_valid, 1);
      chk($sformatf("stall.c%0d.num", c), out_vuop_num, 1);
      chk($sformatf("stall.c%0d.vd", c), out_vd, 17);
      chk($sformatf("stall.c%0d.be", c), out_vbyte_en, 16'hFFFF);
      chk($sformatf("stall.c%0d.last", c), out_last, 0);
      chk($sformatf("stall.c%0d.done", c), done, 0);
      step(); #2;
    end
    out_ready = 1'b1;
    #1;
    for (int k = 1; k < 4; k++) begin
      chk($sformatf("stall.u%0d.valid", k), out_valid, 1);
      chk($sformatf("stall.u%0d.num", k), out_vuop_num, k);
      chk($sformatf("stall.u%0d.last", k), out_last, (k == 3));
      step(); #2;
    end
    chk("stall.end_valid", out_valid, 0);

    // back-to-back
    drive(3'd2, 3'd0, 1'b0, 8'd4, 5'd8, 5'd1, 5'd2);
    #2; step(); in_valid = 1'b0; #2;
    chk("b2b.a.last", out_last, 1);
    drive(3'd0, 3'd1, 1'b0, 8'd20, 5'd4, 5'd5, 5'd6);
    #1;
    chk("b2b.in_ready", in_ready, 1);
    chk("b2b.a.done", done, 1);
    step(); in_valid = 1'b0; #2;
    chk("b2b.b0.valid", out_valid, 1);
    chk("b2b.b0.vd", out_vd, 4);
    chk("b2b.b0.num", out_vuop_num, 0);
    chk("b2b.b0.last", out_last, 0);
    step(); #2;
    chk("b2b.b1.vd", out_vd, 5);
    chk("b2b.b1.be", out_vbyte_en, 16'h000F);
    chk("b2b.b1.last", out_last, 1);
    step(); #2;
    chk("b2b.end_valid", out_valid, 0);

    // flush during uop2, with a competing instruction that must be dropped
    drive(3'd2, 3'd2, 1'b0, 8'd16, 5'd0, 5'd0, 5'd0);
    #2; step(); in_valid = 1'b0; #2;
    step(); #2;
    step(); #2;
    chk("flush.u2.num", out_vuop_num, 2);
    flush = 1'b1;
    drive(3'd2, 3'd0, 1'b0, 8'd16, 5'd9, 5'd9, 5'd9);
    #1;
    chk("flush.done_same", done, 0);
    step();
    flush = 1'b0; in_valid = 1'b0;
    #2;
    chk("flush.valid", out_valid, 0);
    chk("flush.in_ready", in_ready, 1);
    chk("flush.done", done, 0);
    step(); #2;
    chk("flush.dropped", out_valid, 0);
    chk("flush.dropped_done", done, 0);

    // asynchronous reset mid-sequence
    drive(3'd2, 3'd2, 1'b0, 8'd16, 5'd12, 5'd3, 5'd4);
    #2; step(); in_valid = 1'b0; #2;
    step(); #2;
    chk("arst.pre_num", out_vuop_num, 1);
    nRST = 1'b0;
    #1;
    chk("arst.valid", out_valid, 0);
    chk("arst.vd", out_vd, 0);
    chk("arst.num", out_vuop_num, 0);
    chk("arst.be", out_vbyte_en, 0);
    chk("arst.lanes", out_vlaneactive, 0);
    chk("arst.last", out_last, 0);
    chk("arst.done", done, 0);
    step();
    nRST = 1'b1;
    #2;
    chk("arst.in_ready", in_ready, 1);
    chk("arst.post_valid", out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
